// File: rtl/vga_sincronismo.sv
// -----------------------------------------------------------------------------
// vga_sincronismo
//
// VGA timing generator (640x480@60 Hz with the default parameters).
//
// The generator runs on the board clock. An internal divider produces a
// pixel-rate enable, so every downstream renderer stays in the same clock
// domain and only acts on clocks where pix_tick is high.
//
// Ports:
//   clk          in   board clock; all state changes on the rising edge
//   rst_n        in   asynchronous, active-low reset
//   pix_tick     out  pixel enable, high for one clk in every CLK_DIV
//   frame_start  out  one-clk pulse on the last clk of pixel (0,0)
//   coluna       out  horizontal pixel counter, 0..H_TOTAL-1
//   linha        out  vertical line counter, 0..V_TOTAL-1
//   areaAtiva    out  high inside the visible window
//   hsync        out  horizontal sync, active level = SYNC_POL
//   vsync        out  vertical sync, active level = SYNC_POL
//
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
// -----------------------------------------------------------------------------
module vga_sincronismo #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIVEL = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIVEL = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [9:0] coluna,
  output logic [9:0] linha,
  output logic       areaAtiva,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_VISIVEL + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIVEL + V_FP + V_SYNC + V_BP;

  // Divider width; a 1-bit counter that never leaves 0 when CLK_DIV is 1.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_VISIVEL);
  localparam logic [9:0]    V_VIS    = 10'(V_VISIVEL);
  localparam logic [9:0]    HS_START = 10'(H_VISIVEL + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_VISIVEL + H_FP + H_SYNC);
  localparam logic [9:0]    VS_START = 10'(V_VISIVEL + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_VISIVEL + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    coluna_q, coluna_d;
  logic [9:0]    linha_q, linha_d;
  logic          area_q, area_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          tick;

  // Decoded from the registered divider. With CLK_DIV=1 the divider is
  // stuck at its terminal value, so the enable is permanently high.
  assign tick = (div_q == D_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d    = (div_q == D_LAST) ? '0 : div_q + DW'(1);
    coluna_d = coluna_q;
    linha_d  = linha_q;

    if (tick) begin
      if (coluna_q == H_LAST) begin
        coluna_d = '0;
        linha_d  = (linha_q == V_LAST) ? '0 : linha_q + 10'd1;
      end else begin
        coluna_d = coluna_q + 10'd1;
      end
    end

    // Decoded from the next-state counters so that the flags are registered
    // on the same edge as the coordinates: no skew between the tuple fields.
    area_d  = (coluna_d < H_VIS) && (linha_d < V_VIS);
    hsync_d = ((coluna_d >= HS_START) && (coluna_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((linha_d  >= VS_START) && (linha_d  < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset parks the counters on the last blanking pixel of a
  // frame, so the first pixel tick after release lands on (0,0).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      coluna_q <= H_LAST;
      linha_q  <= V_LAST;
      area_q   <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
    end else begin
      div_q    <= div_d;
      coluna_q <= coluna_d;
      linha_q  <= linha_d;
      area_q   <= area_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pix_tick    = tick;
  assign frame_start = tick && (coluna_q == 10'd0) && (linha_q == 10'd0);
  assign coluna      = coluna_q;
  assign linha       = linha_q;
  assign areaAtiva   = area_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule
